sync_fifo_param: RTL and testbench

//  Parametrised single-clock FIFO; next generation of the team's 8-deep synchronous FIFO.

---
 rtl/sync_fifo_param_if.sv | 28 ++
 rtl/sync_fifo_param.sv | 82 ++++++++
 tb/tb_sync_fifo_param.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle for sync_fifo_param. The producer/consumer side
// uses the master modport and the FIFO uses the slave modport.
interface sync_fifo_param_if #(
  parameter int DATAWIDTH = 8,
  parameter int AW        = 4
);
  logic                 wr_en;
  logic [DATAWIDTH-1:0] data_in;
  logic                 r_en;
  logic [DATAWIDTH-1:0] data_out;
  logic                 full;
  logic                 empty;
  logic                 almost_full;
  logic                 almost_empty;
  logic [AW:0]          count;
  logic                 overflow;
  logic                 underflow;

  modport master (
    output wr_en, data_in, r_en,
    input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  wr_en, data_in, r_en,
    output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, sticky error flags and optional FWFT output.
module sync_fifo_param #(
  parameter int DATAWIDTH  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 4,
  parameter int FWFT       = 0
) (
  input  logic              clk,
  input  logic              reset,
  sync_fifo_param_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] AF_TH = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_TH = (AW+1)'(AE_LEVEL);

  logic [DATAWIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]          w_ptr;
  logic [AW:0]          r_ptr;
  logic [AW:0]          count_i;
  logic                 full_i;
  logic                 empty_i;
  logic                 wr_acc;
  logic                 rd_acc;
  logic                 overflow_q;
  logic                 underflow_q;

  // Extra wrap bit on each pointer lets all FIFO_DEPTH entries be used.
  assign count_i = w_ptr - r_ptr;
  assign full_i  = (w_ptr[AW] != r_ptr[AW]) && (w_ptr[AW-1:0] == r_ptr[AW-1:0]);
  assign empty_i = (w_ptr == r_ptr);
  assign wr_acc  = bus.wr_en && !full_i;
  assign rd_acc  = bus.r_en && !empty_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      w_ptr       <= '0;
      r_ptr       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc)
        w_ptr <= w_ptr + 1'b1;
      if (rd_acc)
        r_ptr <= r_ptr + 1'b1;
      if (bus.wr_en && full_i)
        overflow_q <= 1'b1;
      if (bus.r_en && empty_i)
        underflow_q <= 1'b1;
    end
  end

  // Storage is deliberately not reset; writes during reset are dropped.
  always_ff @(posedge clk) begin
    if (wr_acc && !reset)
      mem[w_ptr[AW-1:0]] <= bus.data_in;
  end

  if (FWFT != 0) begin : g_fwft
    assign bus.data_out = mem[r_ptr[AW-1:0]];
  end else begin : g_reg
    logic [DATAWIDTH-1:0] dout_q;

    always_ff @(posedge clk) begin
      if (reset)
        dout_q <= '0;
      else if (rd_acc)
        dout_q <= mem[r_ptr[AW-1:0]];
    end

    assign bus.data_out = dout_q;
  end

  assign bus.count        = count_i;
  assign bus.full         = full_i;
  assign bus.empty        = empty_i;
  assign bus.almost_full  = (count_i >= AF_TH);
  assign bus.almost_empty = (count_i <= AE_TH);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param: one registered-read and one FWFT
// instance (depth 4, width 8, AF=3, AE=1) driven by directed vectors.
module tb_sync_fifo_param;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sync_fifo_param_if #(.DATAWIDTH(8), .AW(2)) bus0 ();
  sync_fifo_param_if #(.DATAWIDTH(8), .AW(2)) bus1 ();

  sync_fifo_param #(.DATAWIDTH(8), .FIFO_DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(0))
    u_reg (.clk(clk), .reset(reset), .bus(bus0));

  sync_fifo_param #(.DATAWIDTH(8), .FIFO_DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1))
    u_fwft (.clk(clk), .reset(reset), .bus(bus1));

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mdl0  [$];
  logic [7:0] mdl1  [$];
  logic [7:0] exp_q [$];
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;
  logic       mon_fire = 1'b0;
  logic       mon_rst  = 1'b0;
  logic       mon_on   = 1'b0;
  logic [7:0] exp_dout = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Registered-read monitor: data_out is checked every cycle, and the
  // expected value advances one cycle after each accepted read.
  always @(negedge clk) begin
    if (mon_on) begin
      if (mon_rst) begin
        exp_dout = 8'h00;
        exp_q.delete();
      end else if (mon_fire) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL scoreboard: read fired with no expected word at %0t", $time);
        end else begin
          exp_dout = exp_q.pop_front();
        end
      end
      chk("data_out", bus0.data_out, exp_dout);
    end
  end

  // FWFT monitor: head word must be presented whenever the model is non-empty.
  always @(negedge clk) begin
    if (mon_on && mdl1.size() != 0)
      chk("fwft data_out", bus1.data_out, mdl1[0]);
  end

  task automatic check0();
    int n;
    n = mdl0.size();
    chk("count", bus0.count, n);
    chk("full", bus0.full, n == 4);
    chk("empty", bus0.empty, n == 0);
    chk("almost_full", bus0.almost_full, n >= 3);
    chk("almost_empty", bus0.almost_empty, n <= 1);
    chk("overflow", bus0.overflow, m_ovf);
    chk("underflow", bus0.underflow, m_udf);
  endtask

  task automatic check1();
    chk("fwft count", bus1.count, mdl1.size());
    chk("fwft empty", bus1.empty, mdl1.size() == 0);
  endtask

  task automatic do_reset(input logic wr, input logic rd);
    reset        = 1'b1;
    bus0.wr_en   = wr;
    bus0.r_en    = rd;
    bus0.data_in = 8'h77;
    bus1.wr_en   = wr;
    bus1.r_en    = rd;
    bus1.data_in = 8'h77;
    @(posedge clk);
    mdl0.delete();
    mdl1.delete();
    m_ovf    = 1'b0;
    m_udf    = 1'b0;
    mon_fire = 1'b0;
    mon_rst  = 1'b1;
    mon_on   = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check0();
    check1();
  endtask

  task automatic step(input logic wr, input logic [7:0] d, input logic rd);
    logic wacc;
    logic racc;
    reset        = 1'b0;
    bus1.wr_en   = 1'b0;
    bus1.r_en    = 1'b0;
    bus0.wr_en   = wr;
    bus0.data_in = d;
    bus0.r_en    = rd;
    wacc = wr && (mdl0.size() != 4);
    racc = rd && (mdl0.size() != 0);
    @(posedge clk);
    if (racc) exp_q.push_back(mdl0.pop_front());
    if (wacc) mdl0.push_back(d);
    if (wr && !wacc) m_ovf = 1'b1;
    if (rd && !racc) m_udf = 1'b1;
    mon_fire = racc;
    mon_rst  = 1'b0;
    @(negedge clk);
    check0();
  endtask

  task automatic step1(input logic wr, input logic [7:0] d, input logic rd);
    logic wacc;
    logic racc;
    reset        = 1'b0;
    bus0.wr_en   = 1'b0;
    bus0.r_en    = 1'b0;
    bus1.wr_en   = wr;
    bus1.data_in = d;
    bus1.r_en    = rd;
    wacc = wr && (mdl1.size() != 4);
    racc = rd && (mdl1.size() != 0);
    @(posedge clk);
    if (racc) void'(mdl1.pop_front());
    if (wacc) mdl1.push_back(d);
    mon_fire = 1'b0;
    mon_rst  = 1'b0;
    @(negedge clk);
    check1();
  endtask

  // {wr, rd, data}: ten writes through a depth-4 FIFO, wr&&rd at count 2 twice.
  logic [9:0] wrap_vec [17] = '{
    10'h201, 10'h202, 10'h203, 10'h100, 10'h304, 10'h205, 10'h100, 10'h306, 10'h207,
    10'h208, 10'h100, 10'h309, 10'h100, 10'h20A, 10'h100, 10'h100, 10'h100
  };

  initial begin
    do_reset(1'b0, 1'b0);

    // fill, flags walk through almost_empty/almost_full/full
    step(1'b1, 8'hA1, 1'b0);
    step(1'b1, 8'hB2, 1'b0);
    step(1'b1, 8'hC3, 1'b0);
    step(1'b1, 8'hD4, 1'b0);
    // rejected write into a full FIFO
    step(1'b1, 8'hEE, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    // drain, then one read too many
    repeat (4) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // simultaneous wr/rd at full and at empty
    do_reset(1'b0, 1'b0);
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    step(1'b1, 8'h44, 1'b0);
    step(1'b1, 8'h55, 1'b1);
    repeat (3) step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h66, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // pointer wrap
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 17; i++) begin
      logic [9:0] v;
      v = wrap_vec[i];
      step(v[9], v[7:0], v[8]);
    end
    step(1'b0, 8'h00, 1'b0);

    // reset mid-stream with both enables high
    do_reset(1'b0, 1'b0);
    step(1'b1, 8'h81, 1'b0);
    step(1'b1, 8'h82, 1'b0);
    step(1'b1, 8'h83, 1'b0);
    step(1'b1, 8'h84, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    do_reset(1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // first-word-fall-through instance
    step1(1'b1, 8'h55, 1'b0);
    step1(1'b0, 8'h00, 1'b0);
    step1(1'b0, 8'h00, 1'b1);
    step1(1'b1, 8'h66, 1'b0);
    step1(1'b1, 8'h77, 1'b0);
    step1(1'b1, 8'h88, 1'b1);
    step1(1'b0, 8'h00, 1'b1);
    step1(1'b0, 8'h00, 1'b1);
    step1(1'b0, 8'h00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
